// File: rtl/mult_seq_param.sv
// Parametrised sequential shift-add multiplier with signed/unsigned modes.
// One operand bit per cycle, full 2*WIDTH-bit product and overflow flag.
module mult_seq_param #(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clock_sign,
    input  logic             reset_sign,
    input  logic             start_sign,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] multiplicant,
    input  logic [WIDTH-1:0] multipliar,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product_hi,
    output logic [WIDTH-1:0] product_lo,
    output logic             overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t             state_q;
    logic [2*WIDTH:0]   acc_q;
    logic [WIDTH-1:0]   mag_a_q;
    logic               neg_q;
    logic               sgn_q;
    logic [CW-1:0]      cnt_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               ovf_q;

    logic               sgn_d;
    logic [WIDTH-1:0]   mag_a_d;
    logic [WIDTH-1:0]   mag_b_d;
    logic               neg_d;
    logic [WIDTH:0]     upper_d;
    logic [2*WIDTH:0]   acc_d;
    logic [2*WIDTH-1:0] res_d;
    logic               ovf_d;

    // Operand magnitudes, one shift-add step and the sign-corrected result.
    always_comb begin
        sgn_d   = signed_mode & SIGNED_EN;
        mag_a_d = multiplicant;
        mag_b_d = multipliar;
        if (sgn_d && multiplicant[WIDTH-1]) begin
            mag_a_d = -multiplicant;
        end
        if (sgn_d && multipliar[WIDTH-1]) begin
            mag_b_d = -multipliar;
        end
        neg_d   = sgn_d & (multiplicant[WIDTH-1] ^ multipliar[WIDTH-1]);
        upper_d = acc_q[2*WIDTH:WIDTH];
        if (acc_q[0]) begin
            upper_d = acc_q[2*WIDTH:WIDTH] + {1'b0, mag_a_q};
        end
        acc_d = {upper_d, acc_q[WIDTH-1:0]} >> 1;
        res_d = acc_q[2*WIDTH-1:0];
        if (neg_q) begin
            res_d = -acc_q[2*WIDTH-1:0];
        end
        if (sgn_q) begin
            ovf_d = res_d[2*WIDTH-1:WIDTH] != {WIDTH{res_d[WIDTH-1]}};
        end else begin
            ovf_d = res_d[2*WIDTH-1:WIDTH] != '0;
        end
    end

    // Control FSM with iteration counter and registered result outputs.
    always_ff @(posedge clock_sign) begin
        if (reset_sign) begin
            state_q <= IDLE;
            acc_q   <= '0;
            mag_a_q <= '0;
            neg_q   <= 1'b0;
            sgn_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_sign) begin
                        mag_a_q <= mag_a_d;
                        acc_q   <= {{(WIDTH+1){1'b0}}, mag_b_d};
                        neg_q   <= neg_d;
                        sgn_q   <= sgn_d;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH-1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    hi_q    <= res_d[2*WIDTH-1:WIDTH];
                    lo_q    <= res_d[WIDTH-1:0];
                    ovf_q   <= ovf_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign product_hi = hi_q;
    assign product_lo = lo_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_mult_seq_param.sv
// Self-checking bench for mult_seq_param at WIDTH=32 (signed and
// unsigned-only builds) and WIDTH=8, against an arithmetic reference.
module tb_mult_seq_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sm;
    logic [31:0] a_in;
    logic [31:0] b_in;
    bit          sel;

    logic        busy32, done32, ov32;
    logic [31:0] hi32, lo32;
    logic        busyn, donen, ovn;
    logic [31:0] hin, lon;
    logic        busy8, done8, ov8;
    logic [7:0]  hi8, lo8;

    logic        busy_m, done_m, ov_m;
    logic [31:0] hi_m, lo_m;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mult_seq_param #(.WIDTH(32), .SIGNED_EN(1'b1)) u32 (
        .clock_sign(clk), .reset_sign(rst), .start_sign(start & ~sel),
        .signed_mode(sm), .multiplicant(a_in), .multipliar(b_in),
        .busy(busy32), .done(done32), .product_hi(hi32),
        .product_lo(lo32), .overflow(ov32)
    );

    mult_seq_param #(.WIDTH(32), .SIGNED_EN(1'b0)) u32n (
        .clock_sign(clk), .reset_sign(rst), .start_sign(start & ~sel),
        .signed_mode(sm), .multiplicant(a_in), .multipliar(b_in),
        .busy(busyn), .done(donen), .product_hi(hin),
        .product_lo(lon), .overflow(ovn)
    );

    mult_seq_param #(.WIDTH(8), .SIGNED_EN(1'b1)) u8 (
        .clock_sign(clk), .reset_sign(rst), .start_sign(start & sel),
        .signed_mode(sm), .multiplicant(a_in[7:0]), .multipliar(b_in[7:0]),
        .busy(busy8), .done(done8), .product_hi(hi8),
        .product_lo(lo8), .overflow(ov8)
    );

    assign busy_m = sel ? busy8 : busy32;
    assign done_m = sel ? done8 : done32;
    assign ov_m   = sel ? ov8 : ov32;
    assign hi_m   = sel ? {24'b0, hi8} : hi32;
    assign lo_m   = sel ? {24'b0, lo8} : lo32;

    task automatic model(input logic [31:0] a, input logic [31:0] b,
                         input bit s, input int w,
                         output logic [31:0] hi, output logic [31:0] lo,
                         output bit ov);
        logic [63:0] mask, au, bu, p;
        longint      sa, sb, sp, lim;
        mask = (64'd1 << w) - 64'd1;
        au   = {32'b0, a} & mask;
        bu   = {32'b0, b} & mask;
        if (s) begin
            sa  = longint'(au << (64 - w));
            sa  = sa >>> (64 - w);
            sb  = longint'(bu << (64 - w));
            sb  = sb >>> (64 - w);
            sp  = sa * sb;
            p   = sp;
            lim = longint'(1) << (w - 1);
            ov  = (sp >= lim) || (sp < -lim);
        end else begin
            p  = au * bu;
            ov = (p >> w) != 64'd0;
        end
        hi = 32'((p >> w) & mask);
        lo = 32'(p & mask);
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b,
                         input bit s);
        a_in  = a;
        b_in  = b;
        sm    = s;
        start = 1'b1;
    endtask

    task automatic wait_result(output int n, output bit busy_bad);
        n        = 0;
        busy_bad = 1'b0;
        @(posedge clk);
        while (n < 200) begin
            @(negedge clk);
            start = 1'b0;
            if (done_m) break;
            if (!busy_m) busy_bad = 1'b1;
            @(posedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        start = 1'b0;
        sm    = 1'b0;
        sel   = 1'b0;
        a_in  = '0;
        b_in  = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy32, done32, ov32, hi32, lo32} !== 67'd0) begin
            errors++;
            $display("FAIL reset32: got b%b d%b o%b %h_%h required zeros",
                     busy32, done32, ov32, hi32, lo32);
        end
        checks++;
        if ({busy8, done8, ov8, hi8, lo8, busyn, donen} !== 21'd0) begin
            errors++;
            $display("FAIL reset8: got b%b d%b o%b %h_%h required zeros",
                     busy8, done8, ov8, hi8, lo8);
        end
        rst = 1'b0;
    endtask

    task automatic test_unsigned_max;
        int n;
        bit bb;
        sel = 1'b0;
        @(negedge clk);
        drive(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        wait_result(n, bb);
        checks++;
        if (n !== 33) begin
            errors++;
            $display("FAIL max_latency: got %0d edges required 33", n);
        end
        checks++;
        if (bb || busy32 !== 1'b0) begin
            errors++;
            $display("FAIL max_busy: gap %b at_done %b required 0 0",
                     bb, busy32);
        end
        checks++;
        if ({hi32, lo32, ov32} !== {32'hFFFFFFFE, 32'h00000001, 1'b1}) begin
            errors++;
            $display("FAIL max_result: got %h_%h ov%b required fffffffe_00000001 ov1",
                     hi32, lo32, ov32);
        end
        @(negedge clk);
        checks++;
        if (done32 !== 1'b0 || hi32 !== 32'hFFFFFFFE) begin
            errors++;
            $display("FAIL max_pulse: got done %b hi %h required 0 fffffffe",
                     done32, hi32);
        end
    endtask

    task automatic test_signed;
        int n;
        bit bb;
        sel = 1'b0;
        @(negedge clk);
        drive(32'hFFFFFFFD, 32'd5, 1'b1);
        wait_result(n, bb);
        checks++;
        if ({hi32, lo32, ov32} !== {32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0}) begin
            errors++;
            $display("FAIL signed_m3x5: got %h_%h ov%b required ffffffff_fffffff1 ov0",
                     hi32, lo32, ov32);
        end
        checks++;
        if ({hin, lon, ovn} !== {32'h00000004, 32'hFFFFFFF1, 1'b1}) begin
            errors++;
            $display("FAIL signed_en0_m3x5: got %h_%h ov%b required 00000004_fffffff1 ov1",
                     hin, lon, ovn);
        end
        drive(32'hFFFFFFFD, 32'd5, 1'b0);
        wait_result(n, bb);
        checks++;
        if ({hi32, lo32, ov32} !== {32'h00000004, 32'hFFFFFFF1, 1'b1}) begin
            errors++;
            $display("FAIL unsigned_m3x5: got %h_%h ov%b required 00000004_fffffff1 ov1",
                     hi32, lo32, ov32);
        end
    endtask

    task automatic test_most_neg;
        int n;
        bit bb;
        sel = 1'b0;
        @(negedge clk);
        drive(32'h80000000, 32'h80000000, 1'b1);
        wait_result(n, bb);
        checks++;
        if ({hi32, lo32, ov32} !== {32'h40000000, 32'h0, 1'b1}) begin
            errors++;
            $display("FAIL most_neg: got %h_%h ov%b required 40000000_00000000 ov1",
                     hi32, lo32, ov32);
        end
        checks++;
        if ({donen, hin, lon, ovn} !== {1'b1, 32'h40000000, 32'h0, 1'b1}) begin
            errors++;
            $display("FAIL most_neg_en0: got d%b %h_%h ov%b required d1 40000000_00000000 ov1",
                     donen, hin, lon, ovn);
        end
    endtask

    task automatic test_busy_ignore;
        int nd;
        sel = 1'b0;
        nd  = 0;
        @(negedge clk);
        drive(32'd7, 32'd6, 1'b0);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        drive(32'd99, 32'd99, 1'b0);
        @(negedge clk);
        start = 1'b0;
        a_in  = 32'd1234;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (done32) nd++;
        end
        checks++;
        if (nd !== 1) begin
            errors++;
            $display("FAIL busy_done_count: got %0d pulses required 1", nd);
        end
        checks++;
        if ({hi32, lo32} !== {32'd0, 32'd42}) begin
            errors++;
            $display("FAIL busy_result: got %h_%h required 00000000_0000002a",
                     hi32, lo32);
        end
    endtask

    task automatic test_reset_abort;
        int n;
        int nd;
        bit bb;
        sel = 1'b0;
        nd  = 0;
        @(negedge clk);
        drive(32'd13, 32'd11, 1'b0);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy32, done32, ov32, hi32, lo32} !== 67'd0) begin
            errors++;
            $display("FAIL abort_state: got b%b d%b o%b %h_%h required zeros",
                     busy32, done32, ov32, hi32, lo32);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done32) nd++;
        end
        checks++;
        if (nd !== 0) begin
            errors++;
            $display("FAIL abort_done: got %0d pulses required 0", nd);
        end
        drive(32'd9, 32'd9, 1'b0);
        wait_result(n, bb);
        checks++;
        if (n !== 33 || {hi32, lo32, ov32} !== {32'd0, 32'd81, 1'b0}) begin
            errors++;
            $display("FAIL abort_restart: got %0d edges %h_%h ov%b required 33 00000000_00000051 ov0",
                     n, hi32, lo32, ov32);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        bit bb;
        sel = 1'b1;
        @(negedge clk);
        drive(32'd200, 32'd3, 1'b0);
        wait_result(n, bb);
        checks++;
        if (n !== 9 || bb || {hi8, lo8, ov8} !== {8'h02, 8'h58, 1'b1}) begin
            errors++;
            $display("FAIL w8_first: got %0d edges gap%b %h_%h ov%b required 9 0 02_58 ov1",
                     n, bb, hi8, lo8, ov8);
        end
        drive(32'h7F, 32'h02, 1'b0);
        wait_result(n, bb);
        checks++;
        if (n !== 9 || bb || {hi8, lo8, ov8} !== {8'h00, 8'hFE, 1'b0}) begin
            errors++;
            $display("FAIL w8_chained: got %0d edges gap%b %h_%h ov%b required 9 0 00_fe ov0",
                     n, bb, hi8, lo8, ov8);
        end
    endtask

    task automatic test_random;
        int          n;
        int          w;
        bit          bb;
        bit          s;
        bit          eo, eno;
        logic [31:0] a, b, eh, el, enh, enl;
        for (int i = 0; i < 30; i++) begin
            sel = i[0];
            w   = sel ? 8 : 32;
            a   = $urandom;
            b   = $urandom;
            if (i < 2) a = '0;
            if (i == 2 || i == 3) b = '0;
            s = 1'($urandom_range(0, 1));
            model(a, b, s, w, eh, el, eo);
            model(a, b, 1'b0, 32, enh, enl, eno);
            @(negedge clk);
            drive(a, b, s);
            wait_result(n, bb);
            checks++;
            if (n !== w + 1 || bb) begin
                errors++;
                $display("FAIL rand_timing[%0d]: got %0d edges gap%b required %0d 0",
                         i, n, bb, w + 1);
            end
            checks++;
            if ({hi_m, lo_m, ov_m} !== {eh, el, eo}) begin
                errors++;
                $display("FAIL rand_result[%0d] w%0d s%b %h*%h: got %h_%h ov%b required %h_%h ov%b",
                         i, w, s, a, b, hi_m, lo_m, ov_m, eh, el, eo);
            end
            if (!sel) begin
                checks++;
                if ({donen, hin, lon, ovn} !== {1'b1, enh, enl, eno}) begin
                    errors++;
                    $display("FAIL rand_en0[%0d] %h*%h: got d%b %h_%h ov%b required d1 %h_%h ov%b",
                             i, a, b, donen, hin, lon, ovn, enh, enl, eno);
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_unsigned_max;
        test_signed;
        test_most_neg;
        test_busy_ignore;
        test_reset_abort;
        test_back_to_back;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_seq_param.md
Name: mult_seq_param

Overview:
- Parametrised sequential shift-add multiplier; successor to the fixed 32-bit multiply datapath.
- Integrates its own control FSM, iteration counter and start/done handshake.
- Returns the full 2*WIDTH-bit product, supports signed and unsigned operands, and flags results that do not fit in WIDTH bits.
- Sits beside the ALU and is driven by the ALU control unit for MULT operations.

Parameters:
- WIDTH, 32, operand width in bits; legal values 4..64. Product is 2*WIDTH bits.
- SIGNED_EN, 1, when 0 the signed_mode input is ignored and all operations are unsigned.

Ports:
- clock_sign  input  1  system clock; all state updates on rising edge.
- reset_sign  input  1  synchronous, active-high reset.
- start_sign  input  1  request a multiply; sampled only in IDLE.
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start_sign.
- multiplicant  input  WIDTH  operand A; captured on the accepted start.
- multipliar  input  WIDTH  operand B; captured on the accepted start.
- busy  output  1  high from the edge after start acceptance until FIX completes.
- done  output  1  single-cycle pulse marking that the result outputs are valid/updated.
- product_hi  output  WIDTH  upper half of product.
- product_lo  output  WIDTH  lower half of product.
- overflow  output  1  product not representable in WIDTH bits (see below).

Behaviour:
- Reset (synchronous, active-high, overrides everything including mid-operation):
  - state=IDLE; busy, done and overflow = 0; product_hi and product_lo = 0; counter=0.
  - No done pulse is produced for an aborted operation.
- FSM states: IDLE, CALC, FIX.
- IDLE:
  - On an edge with start_sign=1: latch operands.
  - Effective signed mode = signed_mode & SIGNED_EN.
  - Signed mode: store the magnitudes of both operands and record neg = signA ^ signB. Unsigned mode: store as-is with neg=0.
  - Initialise the accumulator to {WIDTH+1 zero bits, |B|} and the counter to 0, then go to CALC. busy=1 from this edge.
- CALC, one iteration per edge:
  - If acc[0]=1, add |A| into acc upper part using a WIDTH+1-bit add that keeps the carry.
  - Shift acc right by 1 and increment the counter.
  - After the iteration with counter=WIDTH-1, go to FIX. Exactly WIDTH iterations; no early termination.
- FIX, one edge:
  - The result is acc[2W-1:0], two's-complement negated if neg=1.
  - Write the result to product_hi/product_lo and compute overflow.
  - done<=1, busy<=0, go to IDLE.
- Latency: done is high in the cycle following the (WIDTH+1)th edge after the edge that accepted start (33 edges for WIDTH=32).
- done is a 1-cycle pulse. Result outputs and overflow hold their values until the next FIX or reset.
- Start while busy (CALC/FIX) is ignored, not queued. Operand or signed_mode changes after acceptance have no effect.
- Start in the done cycle is accepted, because the state is already IDLE. This gives back-to-back operation with no gap cycle.
- Overflow rules:
  - Unsigned: overflow = (product_hi != 0).
  - Signed: overflow = (product_hi != WIDTH copies of product_lo[WIDTH-1]).
- Magnitude of the most-negative operand (2^(WIDTH-1)) is held in WIDTH unsigned bits and needs no extra width. most_neg*most_neg = 2^(2W-2) is exact.
- A zero operand follows the normal path: full latency, product 0, overflow 0.

Test Plan:
- WIDTH=32, unsigned, 0xFFFFFFFF*0xFFFFFFFF:
  - product_hi=0xFFFFFFFE, product_lo=0x00000001, overflow=1.
  - done exactly 33 edges after start acceptance, for one cycle; busy high for the 32 iterations plus FIX.
- WIDTH=32, signed, -3*5:
  - product_hi=0xFFFFFFFF, product_lo=0xFFFFFFF1, overflow=0.
  - Same inputs unsigned: hi=0x00000004, lo=0xFFFFFFF1, overflow=1.
- WIDTH=32, signed, 0x80000000*0x80000000:
  - hi=0x40000000, lo=0x00000000, overflow=1.
  - With SIGNED_EN=0 and signed_mode=1, the same inputs give the unsigned result hi=0x40000000, lo=0.
- Busy and reset handling:
  - Start 7*6. At iteration 5, pulse start with new operands and change multiplicant.
  - Result must be 42 with exactly one done.
  - Second run: assert reset_sign at iteration 10. Next cycle busy=0, done=0, outputs 0, and no done ever appears. A fresh start of 9*9 then yields 81.
- WIDTH=8, unsigned, 200*3:
  - product_hi=0x02, product_lo=0x58, overflow=1, done after 9 edges.
  - Hold start_sign=1 in the done cycle with 0x7F*0x02. The second result is hi=0x00, lo=0xFE, overflow=0, with done 9 edges later.
